// File: rtl/boot_loader.sv
// Byte-stream program loader: receives a framed image (address, length, payload, checksum)
// over a valid/ready byte interface, writes the payload into RAM and releases the CPU on a good checksum.
module boot_loader #(
   parameter int          ADDR_W  = 16,
   parameter int          DATA_W  = 8,
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_do,
   output logic              mem_we,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_t;

   state_t            state, state_n;
   logic [15:0]       addr, addr_n;
   logic [15:0]       len, len_n;
   logic [7:0]        csum, csum_n;
   logic [31:0]       idle_cnt, idle_cnt_n;
   logic [ADDR_W-1:0] mem_addr_n;
   logic [DATA_W-1:0] mem_do_n;
   logic              mem_we_n, cpu_rst_n, busy_n, done_n, err_n;
   logic              accept;

   assign rx_ready = (state == S_ADDR_HI) || (state == S_ADDR_LO) || (state == S_LEN_HI) ||
                     (state == S_LEN_LO)  || (state == S_DATA)    || (state == S_CSUM);
   assign accept   = rx_valid && rx_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         addr     <= '0;
         len      <= '0;
         csum     <= '0;
         idle_cnt <= '0;
         mem_addr <= '0;
         mem_do   <= '0;
         mem_we   <= 1'b0;
         cpu_rst  <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_n;
         addr     <= addr_n;
         len      <= len_n;
         csum     <= csum_n;
         idle_cnt <= idle_cnt_n;
         mem_addr <= mem_addr_n;
         mem_do   <= mem_do_n;
         mem_we   <= mem_we_n;
         cpu_rst  <= cpu_rst_n;
         busy     <= busy_n;
         done     <= done_n;
         err      <= err_n;
      end
   end

   always_comb begin
      state_n    = state;
      addr_n     = addr;
      len_n      = len;
      csum_n     = csum;
      idle_cnt_n = idle_cnt;
      mem_addr_n = mem_addr;
      mem_do_n   = mem_do;
      mem_we_n   = 1'b0;
      cpu_rst_n  = cpu_rst;
      busy_n     = busy;
      done_n     = done;
      err_n      = err;

      if (busy) begin
         idle_cnt_n = accept ? 32'd0 : idle_cnt + 32'd1;
      end

      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_n    = S_ADDR_HI;
               busy_n     = 1'b1;
               cpu_rst_n  = 1'b1;
               done_n     = 1'b0;
               err_n      = 1'b0;
               csum_n     = '0;
               idle_cnt_n = '0;
            end
         end
         S_ADDR_HI: if (accept) begin
            addr_n  = {rx_data, addr[7:0]};
            state_n = S_ADDR_LO;
         end
         S_ADDR_LO: if (accept) begin
            addr_n  = {addr[15:8], rx_data};
            state_n = S_LEN_HI;
         end
         S_LEN_HI: if (accept) begin
            len_n   = {rx_data, len[7:0]};
            state_n = S_LEN_LO;
         end
         // A zero-length image skips straight to the checksum byte, which must then be 0x00.
         S_LEN_LO: if (accept) begin
            len_n   = {len[15:8], rx_data};
            state_n = ({len[15:8], rx_data} == 16'd0) ? S_CSUM : S_DATA;
         end
         S_DATA: if (accept) begin
            mem_addr_n = ADDR_W'(addr);
            mem_do_n   = DATA_W'(rx_data);
            mem_we_n   = 1'b1;
            csum_n     = csum + rx_data;
            addr_n     = addr + 16'd1;
            len_n      = len - 16'd1;
            if (len == 16'd1) state_n = S_CSUM;
         end
         S_CSUM: if (accept) begin
            busy_n = 1'b0;
            if (rx_data == csum) begin
               state_n   = S_DONE;
               done_n    = 1'b1;
               cpu_rst_n = 1'b0;
            end else begin
               state_n = S_ERR;
               err_n   = 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase

      // Idle timeout aborts the session; payload already written stays in RAM.
      if (busy && !accept && (TIMEOUT != 0) && (idle_cnt + 32'd1 == TIMEOUT)) begin
         state_n = S_ERR;
         busy_n  = 1'b0;
         err_n   = 1'b1;
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: table-driven frames, hand-written corner sequences
// and randomized frames checked against a frame-level reference model.
module tb_boot_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [15:0] mem_addr;
   logic [7:0]  mem_do;
   logic        mem_we;
   logic        cpu_rst;
   logic        busy;
   logic        done;
   logic        err;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [15:0] wr_addr_q[$];
   logic [7:0]  wr_data_q[$];
   int          wr_cyc_q[$];
   logic [15:0] exp_addr_q[$];
   logic [7:0]  exp_data_q[$];
   bit          exp_done;

   typedef struct {
      logic [0:11][7:0] b;
      int               n;
      int               stall_at;
      int               stall_len;
      bit               exp_done;
      int               exp_wr;
      logic [15:0]      exp_a0;
      bit               exp_consec;
   } vec_t;

   vec_t vecs[4];

   boot_loader #(.ADDR_W(16), .DATA_W(8), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .mem_addr(mem_addr), .mem_do(mem_do), .mem_we(mem_we),
      .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Writes are logged mid-cycle, while the strobe is stable ahead of the RAM's capture edge.
   always @(negedge clk) begin
      if (mem_we) begin
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_do);
         wr_cyc_q.push_back(cyc);
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [7:0] b);
      int waitc = 0;
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      if (!rx_ready) check_output("rx_ready_wait", 32'(rx_ready), 32'd1);
      @(negedge clk);
   endtask

   task automatic do_start(input string name);
      rx_valid = 1'b0;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
      check_output({name, "_start_busy"}, 32'(busy), 32'd1);
      check_output({name, "_start_ready"}, 32'(rx_ready), 32'd1);
      check_output({name, "_start_flags"}, {30'd0, done, err}, 32'd0);
      check_output({name, "_start_cpurst"}, 32'(cpu_rst), 32'd1);
   endtask

   task automatic send_frame(input logic [7:0] fr[$], input int stall_at, input int stall_len,
                             input bit poke);
      for (int i = 0; i < fr.size(); i++) begin
         if (i == stall_at) begin
            rx_valid = 1'b0;
            for (int k = 0; k < stall_len; k++) begin
               start = poke && (k == 0);
               @(negedge clk);
            end
            start = 1'b0;
         end
         apply_stimulus(fr[i]);
      end
      rx_valid = 1'b0;
   endtask

   // Reference: what a frame should do, derived directly from the frame layout.
   task automatic model_frame(input logic [7:0] fr[$]);
      logic [15:0] a;
      int n, sum;
      a   = {fr[0], fr[1]};
      n   = int'({fr[2], fr[3]});
      sum = 0;
      exp_addr_q.delete(); exp_data_q.delete();
      for (int i = 0; i < n; i++) begin
         exp_addr_q.push_back(a);
         exp_data_q.push_back(fr[4 + i]);
         a   = a + 16'd1;
         sum = sum + int'(fr[4 + i]);
      end
      exp_done = (int'(fr[4 + n]) == (sum % 256));
   endtask

   task automatic check_frame(input string name, input bit consec);
      check_output({name, "_wr_count"}, 32'(wr_addr_q.size()), 32'(exp_addr_q.size()));
      for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
         check_output($sformatf("%s_addr%0d", name, i), 32'(wr_addr_q[i]), 32'(exp_addr_q[i]));
         check_output($sformatf("%s_data%0d", name, i), 32'(wr_data_q[i]), 32'(exp_data_q[i]));
         if (consec) check_output($sformatf("%s_cyc%0d", name, i), 32'(wr_cyc_q[i] - wr_cyc_q[0]), 32'(i));
      end
      check_output({name, "_done"}, 32'(done), 32'(exp_done));
      check_output({name, "_err"}, 32'(err), 32'(!exp_done));
      check_output({name, "_cpu_rst"}, 32'(cpu_rst), 32'(!exp_done));
      check_output({name, "_busy"}, 32'(busy), 32'd0);
      check_output({name, "_rx_ready"}, 32'(rx_ready), 32'd0);
   endtask

   task automatic check_reset_values(input string name);
      check_output({name, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
      check_output({name, "_flags"}, {27'd0, rx_ready, mem_we, busy, done, err}, 32'd0);
      check_output({name, "_mem_addr"}, 32'(mem_addr), 32'd0);
      check_output({name, "_mem_do"}, 32'(mem_do), 32'd0);
   endtask

   task automatic run_good_frame(input string name);
      logic [7:0] fr[$];
      fr = '{8'h00, 8'h10, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h31};
      do_start(name);
      model_frame(fr);
      send_frame(fr, -1, 0, 1'b0);
      check_frame(name, 1'b1);
   endtask

   initial begin
      logic [7:0] fr[$];
      int err_k;

      vecs[0] = '{b: {8'h00, 8'h10, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h31, 8'h0, 8'h0, 8'h0, 8'h0},
                  n: 8, stall_at: -1, stall_len: 0, exp_done: 1'b1, exp_wr: 3, exp_a0: 16'h0010, exp_consec: 1'b1};
      vecs[1] = '{b: {8'h00, 8'h10, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h32, 8'h0, 8'h0, 8'h0, 8'h0},
                  n: 8, stall_at: -1, stall_len: 0, exp_done: 1'b0, exp_wr: 3, exp_a0: 16'h0010, exp_consec: 1'b1};
      vecs[2] = '{b: {8'hFF, 8'hFF, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0},
                  n: 7, stall_at: 5, stall_len: 5, exp_done: 1'b1, exp_wr: 2, exp_a0: 16'hFFFF, exp_consec: 1'b0};
      vecs[3] = '{b: {8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0},
                  n: 5, stall_at: -1, stall_len: 0, exp_done: 1'b1, exp_wr: 0, exp_a0: 16'h0000, exp_consec: 1'b0};

      rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;

      // Bytes offered while idle must be ignored.
      rx_valid = 1'b1; rx_data = 8'h55;
      repeat (3) @(negedge clk);
      check_output("idle_rx_ready", 32'(rx_ready), 32'd0);
      check_output("idle_no_write", 32'(wr_addr_q.size()), 32'd0);
      rx_valid = 1'b0;

      for (int v = 0; v < 4; v++) begin
         string name;
         logic [15:0] a;
         name = $sformatf("vec%0d", v);
         fr.delete();
         for (int i = 0; i < vecs[v].n; i++) fr.push_back(vecs[v].b[i]);
         exp_addr_q.delete(); exp_data_q.delete();
         a = vecs[v].exp_a0;
         for (int i = 0; i < vecs[v].exp_wr; i++) begin
            exp_addr_q.push_back(a);
            exp_data_q.push_back(vecs[v].b[4 + i]);
            a = a + 16'd1;
         end
         exp_done = vecs[v].exp_done;
         do_start(name);
         send_frame(fr, vecs[v].stall_at, vecs[v].stall_len, 1'b0);
         check_frame(name, vecs[v].exp_consec);
      end

      // Timeout: header stops after two bytes; err must appear on the 8th idle edge.
      do_start("tmo");
      apply_stimulus(8'h00);
      apply_stimulus(8'h00);
      rx_valid = 1'b0;
      err_k = -1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (err && err_k < 0) err_k = k;
      end
      check_output("tmo_err_cycle", 32'(err_k), 32'd8);
      check_output("tmo_cpu_rst", 32'(cpu_rst), 32'd1);
      check_output("tmo_busy_done", {30'd0, busy, done}, 32'd0);
      run_good_frame("tmo_recover");

      // Asynchronous reset while a payload write is in flight.
      do_start("mid");
      fr = '{8'h00, 8'h20, 8'h00, 8'h05, 8'h11, 8'h22};
      for (int i = 0; i < fr.size(); i++) apply_stimulus(fr[i]);
      rx_valid = 1'b0;
      check_output("mid_we_before", 32'(mem_we), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_reset_values("mid_reset");
      check_output("mid_writes_issued", 32'(wr_addr_q.size()), 32'd2);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_good_frame("mid_recover");

      // Randomized frames with stalls and ignored start pulses.
      for (int r = 0; r < 24; r++) begin
         int n, sum;
         logic [15:0] a;
         n   = $urandom_range(0, 6);
         a   = 16'($urandom);
         sum = 0;
         fr  = '{a[15:8], a[7:0], 8'h00, 8'(n)};
         for (int i = 0; i < n; i++) begin
            fr.push_back(8'($urandom));
            sum = sum + int'(fr[4 + i]);
         end
         if ($urandom_range(0, 3) == 0) fr.push_back(8'((sum + 1 + $urandom_range(0, 254)) % 256));
         else fr.push_back(8'(sum % 256));
         model_frame(fr);
         do_start($sformatf("rnd%0d", r));
         send_frame(fr, $urandom_range(1, fr.size() - 1), $urandom_range(0, 6), 1'($urandom_range(0, 1)));
         check_frame($sformatf("rnd%0d", r), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/boot_loader.md
# boot_loader

Byte-stream program loader that sits upstream of the RAM and fills it before the CPU runs. It holds the CPU in reset while it receives a framed image (start address, length, payload, checksum) over a valid/ready byte interface and writes the payload into RAM. The CPU is released only after a good checksum. This replaces file preloading of RAM with a synthesizable path.

## Interface
- `ADDR_W`, 16: RAM address width.
- `DATA_W`, 8: byte width; the frame format assumes 8.
- `TIMEOUT`, 65535: maximum idle cycles between bytes while a session is active; 0 disables the timeout.

- `clk`  in  1: system clock, shared with the CPU and RAM.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: single-cycle pulse that begins a load session.
- `rx_data`  in  8: incoming frame byte.
- `rx_valid`  in  1: `rx_data` is valid.
- `rx_ready`  out  1: loader can accept a byte. A byte transfers on `rx_valid && rx_ready` at the rising edge.
- `mem_addr`  out  16: RAM write address.
- `mem_do`  out  8: RAM write data; connects to the RAM `di`.
- `mem_we`  out  1: RAM write strobe, one cycle per payload byte.
- `cpu_rst`  out  1: active-high reset driven to the CPU.
- `busy`  out  1: a session is in progress.
- `done`  out  1: the last session completed with a good checksum.
- `err`  out  1: the last session failed, by checksum mismatch or timeout.

## Operation
- **Frame format:** ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, then LEN payload bytes, then CSUM.
  - CSUM = sum of the payload bytes mod 256.
- **State machine:** IDLE, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
- **Reset values:**
  - State IDLE; `cpu_rst`=1.
  - `rx_ready`, `mem_we`, `busy`, `done`, `err` all 0.
  - `mem_addr`=0, `mem_do`=0.
  - Internal address, length, checksum and timeout counters all 0.
- **Starting a session:** `start` in IDLE, DONE or ERR moves to ADDR_HI.
  - Sets `busy`=1, `cpu_rst`=1; clears `done`, `err`, the checksum accumulator and the timeout counter.
  - `start` while `busy` is ignored.
- **Header:** ADDR_HI→ADDR_LO→LEN_HI→LEN_LO, advancing one state per accepted byte. Bytes load the internal address and length registers, big-endian.
- **Leaving LEN_LO:**
  - LEN≠0 → DATA.
  - LEN=0 → CSUM directly; a checksum of 0x00 is then required.
- **DATA state, per accepted byte:**
  - Register `mem_addr`=current address, `mem_do`=byte, `mem_we`=1 for the next cycle.
  - Add the byte to the checksum (8-bit, wraps).
  - Increment the address; it wraps 0xFFFF→0x0000.
  - Decrement the remaining count; on the last byte go to CSUM.
- **CSUM state, on the accepted byte:**
  - Equals the accumulator → DONE: `busy`=0, `done`=1, `cpu_rst`=0.
  - Otherwise → ERR: `busy`=0, `err`=1, `cpu_rst` stays 1.
- **Sticky flags:** `done` and `err` hold until the next `start` or reset.
- **`rx_ready`** = 1 exactly in ADDR_HI through CSUM. It is 0 in IDLE, DONE and ERR; bytes presented there are not consumed.
- **Timeout:**
  - The counter increments each busy cycle without an accepted byte and clears on each accept.
  - Reaching `TIMEOUT` (if nonzero) → ERR.
  - Writes already issued remain in RAM.
- **Reset mid-session:** asynchronously returns everything to reset values. Any in-flight `mem_we` drops immediately and `cpu_rst` returns to 1.

## Timing
- `start` sampled at edge N → `busy`=1 and `rx_ready`=1 after edge N.
- A payload byte accepted at edge N → `mem_we`/`mem_addr`/`mem_do` valid from edge N to N+1; the RAM captures it at edge N+1.
- Back-to-back bytes sustain one byte per cycle; `rx_ready` never deasserts mid-frame.
- Checksum byte accepted at edge N → `done` (or `err`) = 1 and `cpu_rst`=0 (good case) after edge N. `rx_ready`=0 in the same cycle.
- Minimum session length is 5 accepted bytes (LEN=0); it takes 6 cycles including `start`.
- Timeout fires on the edge where the idle count equals `TIMEOUT`; `err` is visible after that edge.

## Test plan
- **Good frame:** after reset, `start`, then stream 00 10 00 03 AA BB CC 31.
  - Required: writes 0x0010=AA, 0x0011=BB, 0x0012=CC on three consecutive cycles.
  - Then `done`=1, `cpu_rst`=0, `err`=0.
- **Bad checksum:** same frame with CSUM=32.
  - Required: all three writes occur; then `err`=1, `cpu_rst`=1, `done`=0.
- **Wrap and stall:** frame FF FF 00 02 01 02 03, with `rx_valid` dropped for 5 cycles mid-payload.
  - Required: writes to 0xFFFF then 0x0000, no extra `mem_we`, then `done`=1.
- **Zero length:** frame 12 34 00 00 00.
  - Required: no `mem_we` at all; `done`=1.
- **Timeout:** `TIMEOUT`=8; send 00 00 then stop.
  - Required: `err`=1 exactly 8 cycles after the last accept; `cpu_rst`=1.
  - A following `start` plus a good frame then gives `done`=1.
- **Mid-session reset:** assert `rst_n`=0 after 2 payload bytes.
  - Required: all outputs return to reset values immediately; `cpu_rst`=1.
  - A subsequent `start` reloads correctly.
